// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB link-initialisation controller: COMRESET/COMINIT/COMWAKE
// handshake, D10.2 and ALIGN exchange, then transmit pass-through from the link layer.
module sata_oob_controller #(
    parameter int unsigned RESET_HOLD      = 16,
    parameter int unsigned WAKE_HOLD       = 16,
    parameter int unsigned TIMEOUT         = 750000,
    parameter int unsigned NONALIGN_NEEDED = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        platform_ready,
    input  logic        comm_init_detect,
    input  logic        comm_wake_detect,
    input  logic        rx_elec_idle,
    input  logic        rx_byte_is_aligned,
    input  logic [31:0] phy_rx_din,
    input  logic [3:0]  phy_rx_isk,
    input  logic [31:0] link_tx_dout,
    input  logic        link_tx_isk,
    output logic        tx_comm_reset,
    output logic        tx_comm_wake,
    output logic        tx_elec_idle,
    output logic [31:0] phy_tx_dout,
    output logic        phy_tx_isk,
    output logic        linkup,
    output logic [3:0]  oob_state,
    output logic [7:0]  retry_count
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_SEND_RESET = 4'd1;
    localparam logic [3:0] ST_WAIT_INIT  = 4'd2;
    localparam logic [3:0] ST_SEND_WAKE  = 4'd3;
    localparam logic [3:0] ST_WAIT_WAKE  = 4'd4;
    localparam logic [3:0] ST_WAIT_IDLE  = 4'd5;
    localparam logic [3:0] ST_SEND_D10   = 4'd6;
    localparam logic [3:0] ST_SEND_ALIGN = 4'd7;
    localparam logic [3:0] ST_READY      = 4'd8;

    localparam logic [31:0] ALIGN_WORD = 32'h7B4A4ABC;
    localparam logic [31:0] D10_WORD   = 32'h4A4A4A4A;

    logic [3:0]  state, state_nxt;
    logic [31:0] cnt;
    logic [7:0]  nonalign_cnt, nonalign_nxt;
    logic        expired, take_timeout;
    logic        rx_prim, rx_align;
    logic        comm_reset_nxt, comm_wake_nxt, elec_idle_nxt, tx_isk_nxt, linkup_nxt;
    logic [31:0] tx_dout_nxt;
    logic [7:0]  retry_nxt;

    assign oob_state = state;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_nxt      = state;
        nonalign_nxt   = 8'd0;
        take_timeout   = 1'b0;
        rx_prim        = (phy_rx_isk == 4'b0001);
        rx_align       = rx_prim && (phy_rx_din == ALIGN_WORD);
        expired        = (cnt >= 32'(TIMEOUT - 1));

        case (state)
            ST_IDLE:       if (platform_ready) state_nxt = ST_SEND_RESET;
            ST_SEND_RESET: if (cnt >= 32'(RESET_HOLD - 1)) state_nxt = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (comm_init_detect) state_nxt = ST_SEND_WAKE;
                else if (expired)     take_timeout = 1'b1;
            end
            ST_SEND_WAKE:  if (cnt >= 32'(WAKE_HOLD - 1)) state_nxt = ST_WAIT_WAKE;
            ST_WAIT_WAKE: begin
                if (comm_wake_detect) state_nxt = ST_WAIT_IDLE;
                else if (expired)     take_timeout = 1'b1;
            end
            ST_WAIT_IDLE: begin
                if (!rx_elec_idle) state_nxt = ST_SEND_D10;
                else if (expired)  take_timeout = 1'b1;
            end
            ST_SEND_D10: begin
                if (rx_align && rx_byte_is_aligned) state_nxt = ST_SEND_ALIGN;
                else if (expired)                   take_timeout = 1'b1;
            end
            ST_SEND_ALIGN: begin
                // Run of non-ALIGN primitives; ALIGN or data words restart it.
                if (rx_prim && !rx_align && nonalign_cnt >= 8'(NONALIGN_NEEDED - 1))
                    state_nxt = ST_READY;
                else begin
                    if (rx_prim && !rx_align) nonalign_nxt = nonalign_cnt + 8'd1;
                    if (expired) take_timeout = 1'b1;
                end
            end
            ST_READY:      if (comm_init_detect) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase

        if (take_timeout) state_nxt = ST_SEND_RESET;
        if (!platform_ready) begin
            state_nxt    = ST_IDLE;
            take_timeout = 1'b0;
        end

        retry_nxt = retry_count;
        if (take_timeout && retry_count != 8'hFF) retry_nxt = retry_count + 8'd1;

        comm_reset_nxt = (state_nxt == ST_SEND_RESET);
        comm_wake_nxt  = (state_nxt == ST_SEND_WAKE);
        elec_idle_nxt  = (state_nxt < ST_SEND_D10);
        linkup_nxt     = (state_nxt == ST_READY);
        tx_dout_nxt    = 32'd0;
        tx_isk_nxt     = 1'b0;
        case (state_nxt)
            ST_SEND_D10:   tx_dout_nxt = D10_WORD;
            ST_SEND_ALIGN: begin
                tx_dout_nxt = ALIGN_WORD;
                tx_isk_nxt  = 1'b1;
            end
            ST_READY: begin
                tx_dout_nxt = link_tx_dout;
                tx_isk_nxt  = link_tx_isk;
            end
            default: begin
                tx_dout_nxt = 32'd0;
                tx_isk_nxt  = 1'b0;
            end
        endcase
    end

    // State, per-state cycle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= 32'd0;
            nonalign_cnt  <= 8'd0;
            tx_comm_reset <= 1'b0;
            tx_comm_wake  <= 1'b0;
            tx_elec_idle  <= 1'b1;
            phy_tx_dout   <= 32'd0;
            phy_tx_isk    <= 1'b0;
            linkup        <= 1'b0;
            retry_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
            nonalign_cnt  <= nonalign_nxt;
            tx_comm_reset <= comm_reset_nxt;
            tx_comm_wake  <= comm_wake_nxt;
            tx_elec_idle  <= elec_idle_nxt;
            phy_tx_dout   <= tx_dout_nxt;
            phy_tx_isk    <= tx_isk_nxt;
            linkup        <= linkup_nxt;
            retry_count   <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_sata_oob_controller.sv
// Directed bench for sata_oob_controller: vector table for the handshake,
// hand sequences for burst lengths, reset abort and timeout/retry behaviour.
module tb_sata_oob_controller;

    localparam logic [31:0] A_W = 32'h7B4A4ABC;
    localparam logic [31:0] D_W = 32'h4A4A4A4A;
    localparam logic [31:0] S_W = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        platform_ready = 1'b0;
    logic        comm_init_detect = 1'b0;
    logic        comm_wake_detect = 1'b0;
    logic        rx_elec_idle = 1'b1;
    logic        rx_byte_is_aligned = 1'b0;
    logic [31:0] phy_rx_din = 32'd0;
    logic [3:0]  phy_rx_isk = 4'd0;
    logic [31:0] link_tx_dout = 32'd0;
    logic        link_tx_isk = 1'b0;
    logic        tx_comm_reset, tx_comm_wake, tx_elec_idle, phy_tx_isk, linkup;
    logic [31:0] phy_tx_dout;
    logic [3:0]  oob_state;
    logic [7:0]  retry_count;

    int checks = 0;
    int failures = 0;

    sata_oob_controller #(
        .RESET_HOLD(16), .WAKE_HOLD(16), .TIMEOUT(100), .NONALIGN_NEEDED(3)
    ) dut (
        .clk(clk), .rst(rst), .platform_ready(platform_ready),
        .comm_init_detect(comm_init_detect), .comm_wake_detect(comm_wake_detect),
        .rx_elec_idle(rx_elec_idle), .rx_byte_is_aligned(rx_byte_is_aligned),
        .phy_rx_din(phy_rx_din), .phy_rx_isk(phy_rx_isk),
        .link_tx_dout(link_tx_dout), .link_tx_isk(link_tx_isk),
        .tx_comm_reset(tx_comm_reset), .tx_comm_wake(tx_comm_wake),
        .tx_elec_idle(tx_elec_idle), .phy_tx_dout(phy_tx_dout),
        .phy_tx_isk(phy_tx_isk), .linkup(linkup),
        .oob_state(oob_state), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        init, wake, ridle, aligned;
        logic [31:0] rdin;
        logic [3:0]  risk;
        logic [31:0] ldout;
        logic        lisk;
        logic [3:0]  e_state;
        logic        e_creset, e_eidle;
        logic [31:0] e_dout;
        logic        e_isk, e_linkup;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic init, logic wake, logic ridle, logic aligned,
                                logic [31:0] rdin, logic [3:0] risk, logic [31:0] ldout,
                                logic lisk, logic [3:0] e_state, logic e_creset,
                                logic e_eidle, logic [31:0] e_dout, logic e_isk,
                                logic e_linkup);
        vec_t v;
        v.init = init; v.wake = wake; v.ridle = ridle; v.aligned = aligned;
        v.rdin = rdin; v.risk = risk; v.ldout = ldout; v.lisk = lisk;
        v.e_state = e_state; v.e_creset = e_creset; v.e_eidle = e_eidle;
        v.e_dout = e_dout; v.e_isk = e_isk; v.e_linkup = e_linkup;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int events;
        logic [3:0] prev;

        // Handshake vectors starting in WAIT_WAKE.
        //                 ini wak rid aln rdin risk ldout         lisk  st    crs eid dout          isk lu
        vecs.push_back(mk(1, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0, 4'd4, 0, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'd0, 4'd0, 32'd0, 0, 4'd5, 0, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0, 4'd5, 0, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'd0, 4'd0, 32'd0, 0, 4'd6, 0, 0, D_W,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, A_W,   4'd1, 32'd0, 0, 4'd6, 0, 0, D_W,   0, 0));
        vecs.push_back(mk(0, 0, 0, 1, A_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, A_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, A_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, D_W,   4'd0, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, A_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'd0, 0, 4'd7, 0, 0, A_W,   1, 0));
        vecs.push_back(mk(0, 0, 0, 1, S_W,   4'd1, 32'h12345678, 1, 4'd8, 0, 0, 32'h12345678, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 32'd0, 4'd0, 32'hAABBCCDD, 0, 4'd8, 0, 0, 32'hAABBCCDD, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 32'd0, 4'd0, 32'd0, 0, 4'd0, 0, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'd0, 4'd0, 32'd0, 0, 4'd1, 1, 1, 32'd0, 0, 0));

        // Reset state
        tick(2);
        chk("rst_state", 32'(oob_state), 32'd0);
        chk("rst_creset", 32'(tx_comm_reset), 32'd0);
        chk("rst_cwake", 32'(tx_comm_wake), 32'd0);
        chk("rst_eidle", 32'(tx_elec_idle), 32'd1);
        chk("rst_dout", phy_tx_dout, 32'd0);
        chk("rst_isk", 32'(phy_tx_isk), 32'd0);
        chk("rst_linkup", 32'(linkup), 32'd0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_wait_ready", 32'(oob_state), 32'd0);

        // COMRESET burst length
        platform_ready = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!tx_comm_reset) break;
            n++;
            tick();
        end
        chk("comreset_len", 32'(n), 32'd16);
        chk("after_reset_state", 32'(oob_state), 32'd2);

        // COMINIT single-cycle pulse, then COMWAKE burst length
        comm_init_detect = 1'b1;
        tick();
        comm_init_detect = 1'b0;
        chk("send_wake_state", 32'(oob_state), 32'd3);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!tx_comm_wake) break;
            n++;
            tick();
        end
        chk("comwake_len", 32'(n), 32'd16);
        chk("after_wake_state", 32'(oob_state), 32'd4);

        // Table-driven handshake through READY and back out
        foreach (vecs[i]) begin
            comm_init_detect   = vecs[i].init;
            comm_wake_detect   = vecs[i].wake;
            rx_elec_idle       = vecs[i].ridle;
            rx_byte_is_aligned = vecs[i].aligned;
            phy_rx_din         = vecs[i].rdin;
            phy_rx_isk         = vecs[i].risk;
            link_tx_dout       = vecs[i].ldout;
            link_tx_isk        = vecs[i].lisk;
            tick();
            chk($sformatf("v%0d_state", i), 32'(oob_state), 32'(vecs[i].e_state));
            chk($sformatf("v%0d_creset", i), 32'(tx_comm_reset), 32'(vecs[i].e_creset));
            chk($sformatf("v%0d_cwake", i), 32'(tx_comm_wake), 32'd0);
            chk($sformatf("v%0d_eidle", i), 32'(tx_elec_idle), 32'(vecs[i].e_eidle));
            chk($sformatf("v%0d_dout", i), phy_tx_dout, vecs[i].e_dout);
            chk($sformatf("v%0d_isk", i), 32'(phy_tx_isk), 32'(vecs[i].e_isk));
            chk($sformatf("v%0d_linkup", i), 32'(linkup), 32'(vecs[i].e_linkup));
        end
        comm_init_detect = 1'b0; comm_wake_detect = 1'b0; rx_elec_idle = 1'b1;
        rx_byte_is_aligned = 1'b0; phy_rx_din = 32'd0; phy_rx_isk = 4'd0;
        link_tx_dout = 32'd0; link_tx_isk = 1'b0;

        // rst during cycle 5 of SEND_RESET aborts the burst
        tick(4);
        chk("abort_pre_creset", 32'(tx_comm_reset), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_creset", 32'(tx_comm_reset), 32'd0);
        chk("abort_state", 32'(oob_state), 32'd0);
        rst = 1'b0;

        // WAIT_INIT timeout after 100 cycles
        tick();
        chk("restart_state", 32'(oob_state), 32'd1);
        tick(16);
        chk("wait_init_entry", 32'(oob_state), 32'd2);
        tick(99);
        chk("wait_init_99", 32'(oob_state), 32'd2);
        tick();
        chk("timeout_state", 32'(oob_state), 32'd1);
        chk("timeout_retry1", 32'(retry_count), 32'd1);

        // Exit condition wins over timeout in the same cycle
        tick(16);
        tick(99);
        comm_init_detect = 1'b1;
        tick();
        comm_init_detect = 1'b0;
        chk("exit_wins_state", 32'(oob_state), 32'd3);
        chk("exit_wins_retry", 32'(retry_count), 32'd1);

        // WAIT_WAKE timeout
        tick(16);
        chk("wait_wake_entry", 32'(oob_state), 32'd4);
        tick(99);
        chk("wait_wake_99", 32'(oob_state), 32'd4);
        tick();
        chk("wake_timeout_state", 32'(oob_state), 32'd1);
        chk("wake_timeout_retry", 32'(retry_count), 32'd2);

        // 298 more timeouts (300 total) saturate retry_count
        events = 0;
        for (int i = 0; i < 60000 && events < 298; i++) begin
            prev = oob_state;
            tick();
            if (prev == 4'd2 && oob_state == 4'd1) events++;
        end
        chk("timeout_events", 32'(events), 32'd298);
        chk("retry_saturated", 32'(retry_count), 32'd255);

        // platform_ready drop returns to IDLE
        platform_ready = 1'b0;
        tick();
        chk("ready_drop_state", 32'(oob_state), 32'd0);
        chk("ready_drop_creset", 32'(tx_comm_reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sata_oob_controller.md
# sata_oob_controller

Host-side SATA out-of-band (OOB) link-initialisation controller. It sits directly above `sata_platform`, in the `clk_75mhz` domain. It drives the platform's `tx_comm_reset`, `tx_comm_wake`, `tx_elec_idle`, `phy_tx_dout` and `phy_tx_isk`. It consumes the platform's COMINIT/COMWAKE detects, electrical-idle status, byte alignment and received words. It runs the COMRESET → COMINIT → COMWAKE → D10.2/ALIGN handshake, then hands the transmit path to the link layer and asserts `linkup`.

## Interface
Parameters:
- `RESET_HOLD`, 16: cycles `tx_comm_reset` is held high per COMRESET.
- `WAKE_HOLD`, 16: cycles `tx_comm_wake` is held high per COMWAKE.
- `TIMEOUT`, 750000: cycles (10 ms at 75 MHz) any wait state may last before retry. Counter width is 32 bits.
- `NONALIGN_NEEDED`, 3: consecutive received non-ALIGN primitives that end alignment.

Ports:
- `clk` in 1: 75 MHz clock (`clk_75mhz`). One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `platform_ready` in 1: PLL locked and transceiver ready.
- `comm_init_detect` in 1: COMINIT received.
- `comm_wake_detect` in 1: COMWAKE received.
- `rx_elec_idle` in 1: receiver in electrical idle.
- `rx_byte_is_aligned` in 1: comma alignment achieved.
- `phy_rx_din` in 32: received word.
- `phy_rx_isk` in 4: per-byte K flags.
- `link_tx_dout` in 32: link-layer transmit word, used in READY only.
- `link_tx_isk` in 1: link-layer K flag for byte 0.
- `tx_comm_reset` out 1: request COMRESET burst.
- `tx_comm_wake` out 1: request COMWAKE burst.
- `tx_elec_idle` out 1: hold transmitter idle.
- `phy_tx_dout` out 32: transmit word.
- `phy_tx_isk` out 1: byte-0 K flag.
- `linkup` out 1: OOB complete, link usable.
- `oob_state` out 4: current state encoding, for debug.
- `retry_count` out 8: timeouts since reset, saturating.

## Operation
- Constants:
  - ALIGN is 32'h7B4A4ABC with isk=1.
  - D10.2 is 32'h4A4A4A4A with isk=0.
  - A received ALIGN is `phy_rx_din`==ALIGN and `phy_rx_isk`==4'b0001.
  - A received primitive is `phy_rx_isk`==4'b0001.
- State encodings, with what the block transmits in each:
  - 0 IDLE: `tx_elec_idle`=1, dout=0. Go to SEND_RESET when `platform_ready`=1.
  - 1 SEND_RESET: `tx_comm_reset`=1 for exactly RESET_HOLD cycles, then WAIT_INIT.
  - 2 WAIT_INIT: on `comm_init_detect` go to SEND_WAKE.
  - 3 SEND_WAKE: `tx_comm_wake`=1 for exactly WAKE_HOLD cycles, then WAIT_WAKE.
  - 4 WAIT_WAKE: on `comm_wake_detect` go to WAIT_IDLE_END.
  - 5 WAIT_IDLE_END: on `rx_elec_idle`=0 go to SEND_D10.
  - 6 SEND_D10: `tx_elec_idle`=0, transmit D10.2. On received ALIGN with `rx_byte_is_aligned`=1, go to SEND_ALIGN.
  - 7 SEND_ALIGN: transmit ALIGN. Count consecutive received primitives that are not ALIGN; any ALIGN or non-primitive word clears the count. At NONALIGN_NEEDED go to READY.
  - 8 READY: `linkup`=1; `phy_tx_dout`/`phy_tx_isk` = `link_tx_dout`/`link_tx_isk`. On `comm_init_detect` (device-initiated reset) or `platform_ready`=0 go to IDLE.
- Timeout applies in states 2, 4, 5, 6 and 7:
  - A single 32-bit counter clears on every state entry.
  - Reaching TIMEOUT without the exit condition → SEND_RESET, and `retry_count` increments, saturating at 255.
- `platform_ready`=0 in any state → IDLE next cycle. This has priority over every other transition.
- `tx_elec_idle`=1 in states 0–5 and 0 in states 6–8.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, `oob_state`=0.
  - `tx_comm_reset`=0, `tx_comm_wake`=0, `tx_elec_idle`=1.
  - `phy_tx_dout`=0, `phy_tx_isk`=0.
  - `linkup`=0, `retry_count`=0.
- Input sampled in cycle N → state change and corresponding output values visible in cycle N+1.
- `tx_comm_reset` is high for RESET_HOLD consecutive cycles, starting the cycle SEND_RESET is entered. The same holds for `tx_comm_wake` in SEND_WAKE.
- A detect pulse of one cycle is sufficient. A detect arriving in a state not waiting for it is ignored, except `comm_init_detect` in READY.
- Timeout and exit condition in the same cycle: the exit condition wins.
- `rst` mid-sequence returns the block to reset values on the next edge, including a `tx_comm_reset` burst already in progress.
- READY transmit pass-through has one cycle of register latency.

## Test plan
- Reset, then `platform_ready`=1 → `tx_comm_reset` high for exactly 16 cycles, then `oob_state`=2.
- Full handshake:
  - Stimulus: COMINIT pulse, COMWAKE pulse, `rx_elec_idle` falling, 3 received ALIGNs with aligned=1, then 3 SYNC (32'hB5B5957C, isk=0001).
  - Required: D10.2 transmitted, then ALIGN, then `linkup`=1 exactly one cycle after the 3rd SYNC is sampled.
- No COMINIT with TIMEOUT=100 → SEND_RESET re-entered after 100 cycles in WAIT_INIT; `retry_count`=1. After 300 forced timeouts `retry_count`=255.
- In SEND_ALIGN, the sequence SYNC, SYNC, ALIGN, SYNC, SYNC, SYNC → `linkup` only after the final SYNC; the interleaved ALIGN resets the count.
- In READY, `link_tx_dout`=32'h12345678 → appears on `phy_tx_dout` next cycle. A `comm_init_detect` pulse in READY → IDLE next cycle with `linkup`=0, then SEND_RESET.
- `rst` asserted during cycle 5 of SEND_RESET → next cycle `tx_comm_reset`=0, `oob_state`=0.
